// File: rtl/serial_tpg.sv
// serial_tpg: LFSR-based serial test pattern generator.
//   A start pulse in IDLE loads seed/poly/length and then shifts out up to
//   `length` bits of a 10-bit Galois-style LFSR, one bit per ready handshake.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, abort    sequence control (start only in IDLE, abort in LOAD/RUN)
//   seed, poly      LFSR initial state and feedback taps (poly[8:0] used)
//   length          number of bits to emit (0..255)
//   ready           downstream accepts Sout this cycle
//   Sout/Sout_valid serial bit (data[0]) and its qualifier (RUN only)
//   data, count     LFSR state, bits transferred so far
//   hist            last 24 transferred bits, newest in [23]
//   busy, done, err LOAD/RUN flag, one-cycle completion pulse, zero-seed flag
module serial_tpg (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  seed,
  input  logic [9:0]  poly,
  input  logic [7:0]  length,
  input  logic        ready,
  output logic        Sout,
  output logic        Sout_valid,
  output logic [9:0]  data,
  output logic [7:0]  count,
  output logic [23:0] hist,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [9:0]  r_data, r_poly;
  logic [7:0]  r_count, r_len;
  logic [23:0] r_hist;
  logic        r_err;

  logic        w_xfer, w_last;
  logic [9:0]  w_fb, w_lfsr;

  assign w_xfer = (r_state == S_RUN) && ready;
  // r_len >= 1 whenever RUN is reached, so the subtraction cannot wrap here.
  assign w_last = w_xfer && (r_count == r_len - 8'd1);

  // Bit 9 always receives data[0]; poly[9] has no tap and is absorbed by the OR.
  assign w_fb   = {10{r_data[0]}} & r_poly;
  assign w_lfsr = {r_data[0] | w_fb[9], r_data[9:1] ^ w_fb[8:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; abort beats completion
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: begin
        if (abort)                                w_next = S_IDLE;
        else if (seed == 10'd0 || length == 8'd0) w_next = S_DONE;
        else                                      w_next = S_RUN;
      end
      S_RUN: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs (no path from ready)
  always_comb begin
    Sout_valid = (r_state == S_RUN);
    busy       = (r_state == S_LOAD) || (r_state == S_RUN);
    done       = (r_state == S_DONE);
  end

  // Datapath: loaded in LOAD, advanced on each transfer, otherwise held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= 10'd0;
      r_poly  <= 10'd0;
      r_count <= 8'd0;
      r_len   <= 8'd0;
      r_hist  <= 24'd0;
      r_err   <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_data  <= seed;
      r_poly  <= poly;
      r_count <= 8'd0;
      r_len   <= length;
      r_hist  <= 24'd0;
      r_err   <= (seed == 10'd0);
    end else if (w_xfer) begin
      r_data  <= w_lfsr;
      r_count <= r_count + 8'd1;
      r_hist  <= {r_data[0], r_hist[23:1]};
    end
  end

  assign Sout  = r_data[0];
  assign data  = r_data;
  assign count = r_count;
  assign hist  = r_hist;
  assign err   = r_err;

endmodule

// File: tb/tb_serial_tpg.sv
module tb_serial_tpg;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [9:0]  seed = '0, poly = '0;
  logic [7:0]  length = '0;
  logic        Sout, Sout_valid, busy, done, err;
  logic [9:0]  data;
  logic [7:0]  count;
  logic [23:0] hist;

  serial_tpg dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .poly(poly),
    .length(length), .ready(ready), .Sout(Sout), .Sout_valid(Sout_valid),
    .data(data), .count(count), .hist(hist), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit chk_en = 0;
  int dcnt = 0, vcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phases of a sequence, LFSR step as shift + conditional tap mask
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3;
  int          ph = P_IDLE;
  logic [9:0]  md = '0, mp = '0;
  logic [7:0]  mc = '0, ml = '0;
  logic [23:0] mh = '0;
  logic        me = 1'b0;
  logic        xs[$];
  logic [9:0]  xd[$];

  function automatic logic [9:0] lfsr_next(input logic [9:0] d, input logic [9:0] p);
    return (d >> 1) ^ (d[0] ? ((p & 10'h1FF) | 10'h200) : 10'h000);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ph = P_IDLE; md = '0; mc = '0; mh = '0; me = 1'b0;
    end else begin
      case (ph)
        P_IDLE: if (start) ph = P_LOAD;
        P_LOAD: begin
          md = seed; mp = poly; ml = length; mc = '0; mh = '0; me = (seed == 0);
          if (abort) ph = P_IDLE;
          else if (seed == 0 || length == 0) ph = P_DONE;
          else ph = P_RUN;
        end
        P_RUN: begin
          bit fin;
          fin = 0;
          if (ready) begin
            xs.push_back(md[0]);
            mh = (mh >> 1) | (24'(md[0]) << 23);
            md = lfsr_next(md, mp);
            xd.push_back(md);
            mc = mc + 1;
            fin = (mc == ml);
          end
          if (abort) ph = P_IDLE;
          else if (fin) ph = P_DONE;
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("Sout", Sout, md[0]);
      chk("Sout_valid", Sout_valid, ph == P_RUN);
      chk("busy", busy, ph == P_LOAD || ph == P_RUN);
      chk("done", done, ph == P_DONE);
      chk("data", data, md);
      chk("count", count, mc);
      chk("hist", hist, mh);
      chk("err", err, me);
      dcnt += int'(done);
      vcnt += int'(Sout_valid);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [9:0] s, input logic [9:0] p, input logic [7:0] l);
    step();
    seed = s; poly = p; length = l; start = 1'b1;
    dcnt = 0; vcnt = 0; xs.delete(); xd.delete();
    step();
    start = 1'b0;
  endtask

  // rmode 0: ready=1, 1: pattern 1,0,0,1,0,1 repeating, 2: random
  task automatic run_seq(input int rmode, input int abort_at, input int rst_at);
    int k = 0;
    for (int n = 0; n < 1000 && ph != P_IDLE; n++) begin
      case (rmode)
        0: ready = 1'b1;
        1: begin ready = (6'b101001 >> (k % 6)) & 1'b1; if (ph == P_RUN) k++; end
        default: ready = 1'($urandom);
      endcase
      abort = (abort_at >= 0 && ph == P_RUN && int'(mc) == abort_at);
      if (abort) ready = 1'b0;
      rst = (rst_at >= 0 && ph == P_RUN && int'(mc) == rst_at);
      step();
    end
    chk("seq_timeout", ph == P_IDLE, 1);
    ready = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  initial begin
    step();
    chk_en = 1;
    step();
    chk("rst_data", data, 0);
    chk("rst_valid", Sout_valid, 0);
    rst = 1'b0;

    // Reference sequence: seed 1, taps 0 and 3, three bits
    launch(10'h001, 10'h009, 8'd3);
    run_seq(0, -1, -1);
    chk("t1_nbits", xs.size(), 3);
    if (xs.size() == 3 && xd.size() == 3) begin
      chk("t1_s0", xs[0], 1); chk("t1_s1", xs[1], 1); chk("t1_s2", xs[2], 1);
      chk("t1_d0", xd[0], 10'h209); chk("t1_d1", xd[1], 10'h30D); chk("t1_d2", xd[2], 10'h38F);
    end
    chk("t1_data", data, 10'h38F);
    chk("t1_count", count, 3);
    chk("t1_hist", hist[23:21], 3'b111);
    chk("t1_done", dcnt, 1);

    // Same with stalls
    launch(10'h001, 10'h009, 8'd3);
    run_seq(1, -1, -1);
    chk("t2_nbits", xs.size(), 3);
    if (xs.size() == 3) begin
      chk("t2_s0", xs[0], 1); chk("t2_s1", xs[1], 1); chk("t2_s2", xs[2], 1);
    end
    chk("t2_data", data, 10'h38F);
    chk("t2_done", dcnt, 1);

    // Zero length
    launch(10'h001, 10'h009, 8'd0);
    run_seq(0, -1, -1);
    chk("t3_valid", vcnt, 0);
    chk("t3_count", count, 0);
    chk("t3_done", dcnt, 1);

    // Zero seed
    launch(10'h000, 10'h009, 8'd5);
    run_seq(0, -1, -1);
    chk("t4_err", err, 1);
    chk("t4_done", dcnt, 1);
    chk("t4_xfers", xs.size(), 0);

    // Abort after 10 transfers
    launch(10'h155, 10'h0A3, 8'd200);
    run_seq(0, 10, -1);
    chk("t5_count", count, 10);
    chk("t5_busy", busy, 0);
    chk("t5_done", dcnt, 0);

    // Reset mid-run, then a fresh sequence
    launch(10'h3C1, 10'h111, 8'd20);
    run_seq(0, -1, 4);
    chk("t6_data", data, 0);
    chk("t6_count", count, 0);
    chk("t6_hist", hist, 0);
    chk("t6_valid", Sout_valid, 0);
    step();
    launch(10'h2A5, 10'h1B3, 8'd7);
    run_seq(2, -1, -1);
    chk("t6_count2", count, 7);
    chk("t6_done2", dcnt, 1);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      start  = ($urandom_range(0, 2) == 0);
      abort  = ($urandom_range(0, 49) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      ready  = 1'($urandom);
      seed   = ($urandom_range(0, 9) == 0) ? 10'h000 : 10'($urandom);
      poly   = 10'($urandom);
      length = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      step();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_tpg.md
SERIAL_TPG -- requirements
Module: serial_tpg

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- abort  in  1  terminate the sequence early; sampled in LOAD/RUN.
- seed  in  10  LFSR initial state, captured in LOAD.
- poly  in  10  feedback taps, bit i gates the XOR into bit i (i=0..8); captured in LOAD.
- length  in  8  number of bits to emit, 0..255; captured in LOAD.
- ready  in  1  downstream accepts Sout this cycle.
- Sout  out  1  serial pattern bit, equal to data[0].
- Sout_valid  out  1  Sout is meaningful; drives the analyzer en.
- data  out  10  current LFSR state.
- count  out  8  bits transferred so far.
- hist  out  24  last 24 transferred bits, newest in [23].
- busy  out  1  high in LOAD or RUN.
- done  out  1  one-cycle completion pulse.
- err  out  1  seed was zero; held until the next start.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-004 IDLE SHALL move to LOAD on the cycle after start=1; otherwise it stays in IDLE.
REQ-005 LOAD SHALL do all of the following in one cycle:
- data<=seed, count<=0, hist<=0, err<=0.
- capture poly and length into internal registers.
- go to RUN.
REQ-006 LOAD SHALL go to DONE instead of RUN if length==0.
REQ-007 LOAD SHALL go to DONE with err<=1 if seed==0, because the all-zero state is a lockup.
REQ-008 In RUN, Sout_valid SHALL be 1 and Sout SHALL equal data[0].
REQ-009 A transfer SHALL occur when Sout_valid=1 and ready=1 in the same cycle.
REQ-010 On each transfer the block SHALL update, in the same cycle:
- data[9]<=data[0].
- data[i]<=data[i+1]^(data[0]&poly[i]) for i=0..8.
- count<=count+1.
- hist<={Sout,hist[23:1]}.
REQ-011 With ready=0 in RUN, data, count and hist SHALL hold, and Sout/Sout_valid SHALL stay stable.
REQ-012 A transfer with count==length-1 SHALL move RUN to DONE; the bit transferred in that cycle is the final bit.
REQ-013 count SHALL never exceed length and SHALL NOT wrap.
REQ-014 DONE SHALL last exactly one cycle with done=1 and Sout_valid=0, then return to IDLE.
REQ-015 data, count, hist and err SHALL hold their values in DONE and IDLE until the next LOAD.
REQ-016 abort=1 in LOAD or RUN SHALL send the FSM to IDLE next cycle with no done pulse.
REQ-017 If abort and the final transfer occur in the same cycle, abort SHALL win: no done pulse, but the transfer's state update still happens.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 In IDLE, start and abort both at 1 SHALL give LOAD, since abort is ignored in IDLE.
REQ-020 Sout_valid SHALL be 0 in IDLE, LOAD and DONE.
REQ-021 All outputs SHALL be registered or decoded directly from state, with no combinational path from ready to Sout_valid.

Reset
REQ-022 rst=1 SHALL force, in any state including mid-RUN, on the next posedge:
- FSM=IDLE.
- data=10'h000, count=0, hist=0.
- Sout=0, Sout_valid=0, busy=0, done=0, err=0.
REQ-023 rst SHALL take priority over start, abort and ready.

Verification
REQ-024 seed=10'h001, poly=10'h009, length=3, ready=1 -> required response:
- Sout sequence 1,1,1.
- data after each transfer 0x209, 0x30D, 0x38F.
- count=3, hist[23:21]=3'b111, done pulses once.
REQ-025 The same stimulus with ready toggling 1,0,0,1,0,1 -> same Sout sequence and final data=0x38F; data holds on every ready=0 cycle.
REQ-026 length=0, seed=10'h001 -> IDLE, LOAD, DONE, IDLE; Sout_valid is never 1; count=0; done pulses once.
REQ-027 seed=10'h000, length=5 -> err=1 and done pulses once; no transfers.
REQ-028 Run with length=200, abort asserted after 10 transfers -> count=10, IDLE the next cycle, done stays 0.
REQ-029 rst asserted after 4 transfers in RUN -> all outputs at reset values next cycle; start two cycles later runs normally from the new seed.
